// File: rtl/time_set_pkg.sv
// Shared types, constants and wrap-around helpers for the time-setting controller.
package time_set_pkg;

  localparam int HOUR_W = 5;
  localparam int MS_W   = 6;

  localparam logic [HOUR_W-1:0] HOUR_MIN = 5'd1;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd12;
  localparam logic [MS_W-1:0]   MS_MAX   = 6'd59;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_H    = 2'd1,
    FIELD_M    = 2'd2,
    FIELD_S    = 2'd3
  } field_t;

  // Anything at or above the maximum (including garbage) wraps to the minimum.
  function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
    next_hour = (h >= HOUR_MAX) ? HOUR_MIN : h + 5'd1;
  endfunction

  function automatic logic [MS_W-1:0] next_ms(input logic [MS_W-1:0] v);
    next_ms = (v >= MS_MAX) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_debounce.sv
// Push-button debouncer: one sampling flop, stability counter, rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          samp_r;
  logic          level_r;
  logic          level_d_r;
  logic [CW-1:0] cnt_r;

  // Level flips only after the sample has disagreed with it for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      samp_r    <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      samp_r    <= raw_i;
      level_d_r <= level_r;
      if (samp_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_r <= samp_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign level_o = level_r;
  assign press_o = level_r & ~level_d_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller feeding the set port of the 12-hour clock core.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              mode_i,
  input  logic              inc_i,
  input  logic              cancel_i,
  input  logic [HOUR_W-1:0] hour_i,
  input  logic [MS_W-1:0]   min_i,
  input  logic [MS_W-1:0]   sec_i,
  output logic              Timeset,
  output logic [HOUR_W-1:0] Hourset,
  output logic [MS_W-1:0]   Minset,
  output logic [MS_W-1:0]   Secset,
  output logic              edit_o,
  output logic [1:0]        field_o
);

  localparam int RPT_W = $clog2(2 * REPEAT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic mode_p, inc_p, cancel_p;
  logic mode_lvl, inc_lvl, cancel_lvl;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk_i(clk_i), .reset_i(reset_i), .raw_i(mode_i), .level_o(mode_lvl), .press_o(mode_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk_i(clk_i), .reset_i(reset_i), .raw_i(inc_i), .level_o(inc_lvl), .press_o(inc_p));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk_i(clk_i), .reset_i(reset_i), .raw_i(cancel_i), .level_o(cancel_lvl), .press_o(cancel_p));

  state_t           state_r, state_n;
  logic [RPT_W-1:0] rpt_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             in_edit, to_hit, abort, rpt_run, rpt_tick, inc_evt;
  logic             edit_n;
  logic [1:0]       field_n;

  assign in_edit  = (state_r == ST_EDIT_H) || (state_r == ST_EDIT_M) || (state_r == ST_EDIT_S);
  assign to_hit   = in_edit && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  assign abort    = in_edit && (cancel_p || to_hit);
  // Holding mode or cancel suppresses repeat; a state change restarts it.
  assign rpt_run  = in_edit && inc_lvl && !mode_lvl && !cancel_lvl && (state_n == state_r);
  assign rpt_tick = rpt_run && (rpt_cnt_r == RPT_W'(2 * REPEAT_CYCLES - 1));
  assign inc_evt  = in_edit && !abort && !mode_p && (inc_p || rpt_tick);

  // Next-state and Moore decode of the next state (registered below).
  always_comb begin
    state_n = state_r;
    edit_n  = 1'b0;
    field_n = FIELD_NONE;
    case (state_r)
      ST_IDLE:   if (mode_p) state_n = ST_EDIT_H; else state_n = ST_IDLE;
      ST_EDIT_H: if (abort) state_n = ST_IDLE; else if (mode_p) state_n = ST_EDIT_M; else state_n = ST_EDIT_H;
      ST_EDIT_M: if (abort) state_n = ST_IDLE; else if (mode_p) state_n = ST_EDIT_S; else state_n = ST_EDIT_M;
      ST_EDIT_S: if (abort) state_n = ST_IDLE; else if (mode_p) state_n = ST_COMMIT; else state_n = ST_EDIT_S;
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    case (state_n)
      ST_EDIT_H: begin edit_n = 1'b1; field_n = FIELD_H; end
      ST_EDIT_M: begin edit_n = 1'b1; field_n = FIELD_M; end
      ST_EDIT_S: begin edit_n = 1'b1; field_n = FIELD_S; end
      default:   begin edit_n = 1'b0; field_n = FIELD_NONE; end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
      edit_o  <= 1'b0;
      field_o <= FIELD_NONE;
      Timeset <= 1'b0;
    end else begin
      state_r <= state_n;
      edit_o  <= edit_n;
      field_o <= field_n;
      Timeset <= (state_r == ST_EDIT_S) && mode_p && !abort;
    end
  end

  // Field registers: capture on entry, then step the active field.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      Hourset <= HOUR_MAX;
      Minset  <= 6'd0;
      Secset  <= 6'd0;
    end else if ((state_r == ST_IDLE) && mode_p) begin
      Hourset <= hour_i;
      Minset  <= min_i;
      Secset  <= sec_i;
    end else if (inc_evt) begin
      case (state_r)
        ST_EDIT_H: Hourset <= next_hour(Hourset);
        ST_EDIT_M: Minset  <= next_ms(Minset);
        ST_EDIT_S: Secset  <= next_ms(Secset);
        default:   Hourset <= Hourset;
      endcase
    end else begin
      Hourset <= Hourset;
    end
  end

  // Auto-repeat: first tick 2*REPEAT_CYCLES after the press, then every REPEAT_CYCLES.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rpt_cnt_r <= '0;
    end else if (inc_p || !rpt_run) begin
      rpt_cnt_r <= '0;
    end else if (rpt_tick) begin
      rpt_cnt_r <= RPT_W'(REPEAT_CYCLES);
    end else begin
      rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
    end
  end

  // Inactivity timer; repeat ticks are not user presses and do not refresh it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      to_cnt_r <= '0;
    end else if (!in_edit || (state_n != state_r) || mode_p || inc_p || cancel_p) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with default parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       mode_i = 1'b0, inc_i = 1'b0, cancel_i = 1'b0;
  logic [4:0] hour_i = 5'd0;
  logic [5:0] min_i = 6'd0, sec_i = 6'd0;
  logic       Timeset, edit_o;
  logic [4:0] Hourset;
  logic [5:0] Minset, Secset;
  logic [1:0] field_o;

  int n_cmp = 0;
  int n_err = 0;
  int ts_count = 0;
  int ts_base;
  logic [4:0] ts_h;
  logic [5:0] ts_m, ts_s;

  always #5 clk = ~clk;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .inc_i(inc_i), .cancel_i(cancel_i),
    .hour_i(hour_i), .min_i(min_i), .sec_i(sec_i), .Timeset(Timeset), .Hourset(Hourset),
    .Minset(Minset), .Secset(Secset), .edit_o(edit_o), .field_o(field_o));

  always @(negedge clk) begin
    if (Timeset === 1'b1) begin
      ts_count++;
      ts_h = Hourset;
      ts_m = Minset;
      ts_s = Secset;
    end
  end

  // Raw buttons high for 'hold' edges, then low long enough for the debouncer to settle.
  task automatic press(input logic m, input logic i, input logic c, input int hold);
    mode_i = m; inc_i = i; cancel_i = c;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    mode_i = 1'b0; inc_i = 1'b0; cancel_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (Timeset !== 1'b0) begin n_err++; $display("FAIL reset_timeset: got %0b want 0", Timeset); end
    n_cmp++; if (Hourset !== 5'd12) begin n_err++; $display("FAIL reset_hour: got %0d want 12", Hourset); end
    n_cmp++; if (Minset !== 6'd0) begin n_err++; $display("FAIL reset_min: got %0d want 0", Minset); end
    n_cmp++; if (Secset !== 6'd0) begin n_err++; $display("FAIL reset_sec: got %0d want 0", Secset); end
    n_cmp++; if (edit_o !== 1'b0) begin n_err++; $display("FAIL reset_edit: got %0b want 0", edit_o); end
    n_cmp++; if (field_o !== 2'd0) begin n_err++; $display("FAIL reset_field: got %0d want 0", field_o); end
  endtask

  task automatic test_capture();
    hour_i = 5'd11; min_i = 6'd59; sec_i = 6'd59;
    press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (field_o !== 2'd1) begin n_err++; $display("FAIL capture_field: got %0d want 1", field_o); end
    n_cmp++; if (edit_o !== 1'b1) begin n_err++; $display("FAIL capture_edit: got %0b want 1", edit_o); end
    n_cmp++; if (Hourset !== 5'd11) begin n_err++; $display("FAIL capture_hour: got %0d want 11", Hourset); end
    n_cmp++; if (Minset !== 6'd59) begin n_err++; $display("FAIL capture_min: got %0d want 59", Minset); end
    n_cmp++; if (Secset !== 6'd59) begin n_err++; $display("FAIL capture_sec: got %0d want 59", Secset); end
  endtask

  task automatic test_inc_wrap();
    press(1'b0, 1'b1, 1'b0, 6);
    n_cmp++; if (Hourset !== 5'd12) begin n_err++; $display("FAIL inc_hour_12: got %0d want 12", Hourset); end
    press(1'b0, 1'b1, 1'b0, 6);
    n_cmp++; if (Hourset !== 5'd1) begin n_err++; $display("FAIL inc_hour_wrap: got %0d want 1", Hourset); end
    press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (field_o !== 2'd2) begin n_err++; $display("FAIL field_min: got %0d want 2", field_o); end
    press(1'b0, 1'b1, 1'b0, 6);
    n_cmp++; if (Minset !== 6'd0) begin n_err++; $display("FAIL inc_min_wrap: got %0d want 0", Minset); end
    n_cmp++; if (Hourset !== 5'd1) begin n_err++; $display("FAIL min_no_carry: got %0d want 1", Hourset); end
  endtask

  task automatic test_commit();
    press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (field_o !== 2'd3) begin n_err++; $display("FAIL field_sec: got %0d want 3", field_o); end
    ts_base = ts_count;
    press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (ts_count !== ts_base + 1) begin n_err++; $display("FAIL commit_strobes: got %0d want 1", ts_count - ts_base); end
    n_cmp++; if ({ts_h, ts_m, ts_s} !== {5'd1, 6'd0, 6'd59}) begin n_err++; $display("FAIL commit_values: got %0d:%0d:%0d want 1:0:59", ts_h, ts_m, ts_s); end
    n_cmp++; if (edit_o !== 1'b0) begin n_err++; $display("FAIL commit_edit: got %0b want 0", edit_o); end
    n_cmp++; if (field_o !== 2'd0) begin n_err++; $display("FAIL commit_field: got %0d want 0", field_o); end
  endtask

  task automatic test_repeat();
    hour_i = 5'd3; min_i = 6'd7; sec_i = 6'd0;
    repeat (3) press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (field_o !== 2'd3) begin n_err++; $display("FAIL rpt_field: got %0d want 3", field_o); end
    press(1'b0, 1'b1, 1'b0, 2);
    n_cmp++; if (Secset !== 6'd0) begin n_err++; $display("FAIL glitch_ignored: got %0d want 0", Secset); end
    press(1'b0, 1'b1, 1'b0, 40);
    n_cmp++; if (Secset !== 6'd4) begin n_err++; $display("FAIL auto_repeat: got %0d want 4", Secset); end
    ts_base = ts_count;
    press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (ts_count !== ts_base + 1) begin n_err++; $display("FAIL rpt_commit_strobes: got %0d want 1", ts_count - ts_base); end
    n_cmp++; if ({ts_h, ts_m, ts_s} !== {5'd3, 6'd7, 6'd4}) begin n_err++; $display("FAIL rpt_commit_values: got %0d:%0d:%0d want 3:7:4", ts_h, ts_m, ts_s); end
  endtask

  task automatic test_cancel_mode();
    hour_i = 5'd5; min_i = 6'd30; sec_i = 6'd15;
    ts_base = ts_count;
    press(1'b1, 1'b0, 1'b0, 6);
    press(1'b1, 1'b0, 1'b0, 6);
    n_cmp++; if (field_o !== 2'd2) begin n_err++; $display("FAIL cancel_pre_field: got %0d want 2", field_o); end
    press(1'b1, 1'b0, 1'b1, 6);
    n_cmp++; if (field_o !== 2'd0) begin n_err++; $display("FAIL cancel_field: got %0d want 0", field_o); end
    n_cmp++; if (ts_count !== ts_base) begin n_err++; $display("FAIL cancel_no_strobe: got %0d want 0", ts_count - ts_base); end
    n_cmp++; if (Minset !== 6'd30) begin n_err++; $display("FAIL cancel_keeps_min: got %0d want 30", Minset); end
  endtask

  task automatic test_timeout();
    ts_base = ts_count;
    press(1'b1, 1'b0, 1'b0, 6);
    repeat (53) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (field_o !== 2'd1) begin n_err++; $display("FAIL timeout_early: got %0d want 1", field_o); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (field_o !== 2'd0) begin n_err++; $display("FAIL timeout_abort: got %0d want 0", field_o); end
    n_cmp++; if (ts_count !== ts_base) begin n_err++; $display("FAIL timeout_no_strobe: got %0d want 0", ts_count - ts_base); end
  endtask

  task automatic test_async_reset();
    hour_i = 5'd9; min_i = 6'd45; sec_i = 6'd30;
    ts_base = ts_count;
    repeat (3) press(1'b1, 1'b0, 1'b0, 6);
    press(1'b0, 1'b1, 1'b0, 6);
    n_cmp++; if (Secset !== 6'd31) begin n_err++; $display("FAIL ar_pre_sec: got %0d want 31", Secset); end
    #2 reset_i = 1'b0;
    #1;
    n_cmp++; if ({Hourset, Minset, Secset} !== {5'd12, 6'd0, 6'd0}) begin n_err++; $display("FAIL ar_values: got %0d:%0d:%0d want 12:0:0", Hourset, Minset, Secset); end
    n_cmp++; if ({edit_o, field_o, Timeset} !== 4'b0000) begin n_err++; $display("FAIL ar_ctrl: got %b want 0000", {edit_o, field_o, Timeset}); end
    @(negedge clk);
    reset_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (field_o !== 2'd0) begin n_err++; $display("FAIL ar_idle: got %0d want 0", field_o); end
    n_cmp++; if (ts_count !== ts_base) begin n_err++; $display("FAIL ar_no_strobe: got %0d want 0", ts_count - ts_base); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_inc_wrap();
    test_commit();
    test_repeat();
    test_cancel_mode();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting controller that drives the set port of `digital_clk_12hr` (`Timeset`, `Hourset`, `Minset`, `Secset`). It sits between raw board push-buttons and the clock core. It seeds the editable fields from the clock's live outputs, lets the user step hour, minute and second, and then issues a one-cycle load. Edits can be abandoned by a cancel press or an inactivity timeout.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required before a button level is accepted.
- `REPEAT_CYCLES`, default 8: held-`inc` auto-repeat period in cycles. The first repeat fires 2×`REPEAT_CYCLES` after the accepted press.
- `TIMEOUT_CYCLES`, default 64: idle cycles in any edit state before an automatic abort.

Ports:
- `clk_i`  in  1  system clock, rising-edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `mode_i`  in  1  raw mode button, active-high: enters edit mode and advances the field.
- `inc_i`  in  1  raw increment button, active-high.
- `cancel_i`  in  1  raw cancel button, active-high.
- `hour_i`  in  5  live hour from the clock, 1..12.
- `min_i`  in  6  live minute, 0..59.
- `sec_i`  in  6  live second, 0..59.
- `Timeset`  out  1  one-cycle load strobe to the clock.
- `Hourset`  out  5  hour to load, 1..12.
- `Minset`  out  6  minute to load, 0..59.
- `Secset`  out  6  second to load, 0..59.
- `edit_o`  out  1  high in any edit state; used for display blinking.
- `field_o`  out  2  field being edited: 0 none, 1 hour, 2 min, 3 sec.

## Operation
- Each raw button passes through a debouncer and a rising-edge detector. All FSM decisions use the debounced press pulses (`mode_p`, `inc_p`, `cancel_p`).
- FSM states: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- IDLE, on `mode_p`:
  - capture `hour_i`/`min_i`/`sec_i` into `Hourset`/`Minset`/`Secset`;
  - go to EDIT_H.
- EDIT_H, on `mode_p`: go to EDIT_M. EDIT_M, on `mode_p`: go to EDIT_S. EDIT_S, on `mode_p`: go to COMMIT.
- COMMIT: `Timeset`=1 for exactly one cycle, then return to IDLE unconditionally.
- `inc_p` or an auto-repeat tick in an edit state increments the active field:
  - hour wraps 12→1;
  - minute and second wrap 59→0;
  - no carry between fields.
- An out-of-range captured value is never produced. Capture takes the inputs as-is, and an increment from any value ≥ max wraps to the minimum: hour 0 or >12 becomes 1; minute/second >59 becomes 0.
- `cancel_p` in an edit state returns to IDLE with no `Timeset`. `Hourset`/`Minset`/`Secset` keep their values, which the clock ignores because no strobe is issued.
- Timeout counter:
  - cleared on every state change and every accepted press;
  - reaching `TIMEOUT_CYCLES` in an edit state behaves as `cancel_p`.
- Priority when events coincide in the same cycle: cancel > mode > inc. Only one action is taken per cycle.
- `inc_p` and `cancel_p` are ignored in IDLE and COMMIT. `mode_p` is ignored in COMMIT.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `Timeset`=0, `Hourset`=12, `Minset`=0, `Secset`=0, `edit_o`=0, `field_o`=0. The debouncers, repeat counter and timeout counter all clear.
- Debounce latency: a raw edge is accepted `DEBOUNCE_CYCLES`+1 cycles after the first stable sample. The press pulse is one cycle wide.
- Field update latency: the field register changes on the clock edge after the press pulse. `Hourset`/`Minset`/`Secset` are registered outputs.
- `Timeset` is registered. It is high in the cycle after the EDIT_S `mode_p` edge. The `*set` outputs are stable in that cycle and the cycle after it.
- `edit_o` and `field_o` are Moore outputs decoded from the state register: `edit_o`=1 in EDIT_H/EDIT_M/EDIT_S, `field_o`=1/2/3 in EDIT_H/EDIT_M/EDIT_S, and both 0 in IDLE and COMMIT.
- Auto-repeat:
  - active only while the debounced `inc` level is high in an edit state;
  - counter restarts on a field change;
  - mode or cancel presses stop the repeat.
- If reset asserts mid-edit, the controller returns to IDLE immediately and no `Timeset` is issued.

## Structure
- Package `time_set_pkg` holds:
  - state enum;
  - field codes FIELD_NONE/H/M/S;
  - constants HOUR_MIN=1, HOUR_MAX=12, MS_MAX=59;
  - widths HOUR_W=5, MS_W=6.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk_i`, `reset_i`, `raw_i`, `level_o`, `press_o`) is instantiated three times.
- The FSM, field registers, repeat counter and timeout counter live in the top module.

## Test plan
- Reset, then `mode_i` held for 6 cycles with live inputs 11:59:59 → EDIT_H, `Hourset`=11, `Minset`=59, `Secset`=59, `field_o`=1.
- In EDIT_H at `Hourset`=11, two clean `inc` presses → `Hourset` goes 12 then 1. In EDIT_M at `Minset`=59, one press → `Minset`=0 and `Hourset` is unchanged.
- Full sequence of mode ×4 → exactly one cycle of `Timeset`=1 with the edited values, then IDLE with `edit_o`=0.
- `inc_i` held 40 cycles in EDIT_S from `Secset`=0 → 1 on the press, then 1 repeat every 8 cycles after a 16-cycle delay, ending at `Secset`=4. A 2-cycle glitch on `inc_i` → no change.
- `cancel_i` and `mode_i` accepted in the same cycle in EDIT_M → IDLE, no `Timeset`. Separately, 64 idle cycles in EDIT_H → IDLE, no `Timeset`.
- `reset_i` pulsed low asynchronously between clock edges while in EDIT_S → outputs at reset values at once. `Timeset` is never asserted.
